// File: rtl/uart_rx_tx.sv
// -----------------------------------------------------------------------------
// uart_rx_tx
//   Full-duplex 8N1 UART. The transmitter and receiver share clk/reset but
//   are otherwise independent. Frame: start(0), d[0]..d[7] LSB first, stop(1).
//   Each bit lasts CLKS_PER_BIT = CLK_FREQ/BAUD_RATE clocks (must be >= 4).
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-low reset
//   tx_start  in   1  send request, sampled only while tx_busy=0
//   tx_data   in   8  byte to send, latched on the accepting edge
//   tx        out  1  serial output, idle high
//   tx_busy   out  1  high from the accepting edge until the stop bit ends
//   rx        in   1  serial input, asynchronous to clk
//   rx_data   out  8  last valid received byte
//   rx_ready  out  1  one-cycle pulse when rx_data is updated
//
// Configuration macro
//   UART_LOOPBACK_EN : when defined, the receiver listens to the internal tx
//                      signal and the rx pin is ignored.
// -----------------------------------------------------------------------------
module uart_rx_tx #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // =========================================================================
    // Transmitter
    // =========================================================================
    state_t           r_tx_state;
    state_t           w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] w_tx_cnt_nxt;
    logic [2:0]       r_tx_idx;
    logic [2:0]       w_tx_idx_nxt;
    logic [7:0]       r_tx_data;
    logic             r_tx;
    logic             r_tx_busy;
    logic             w_tx_nxt;
    logic             w_tx_busy_nxt;
    logic             w_tx_bit_end;
    logic             w_tx_accept;

    assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
    assign w_tx_accept  = (r_tx_state == S_IDLE) && tx_start;

    // State register; tx and tx_busy are registered from the next state so
    // the line changes on the same edge the FSM does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_data  <= '0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
            if (w_tx_accept) begin
                r_tx_data <= tx_data;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        w_tx_idx_nxt   = r_tx_idx;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (tx_start) begin
                    w_tx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nxt = S_DATA;
                    w_tx_cnt_nxt   = '0;
                    w_tx_idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt = '0;
                    w_tx_idx_nxt = r_tx_idx + 1'b1;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nxt = S_IDLE;
                    w_tx_cnt_nxt   = '0;
                end
            end
            default: begin
                w_tx_state_nxt = S_IDLE;
                w_tx_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic (value the line takes after this edge)
    always_comb begin
        w_tx_busy_nxt = (w_tx_state_nxt != S_IDLE);
        case (w_tx_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = r_tx_data[w_tx_idx_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign tx      = r_tx;
    assign tx_busy = r_tx_busy;

    // =========================================================================
    // Receiver
    // =========================================================================
    logic             w_rx_src;
    logic             r_rx_meta;
    logic             r_rx_s;
    state_t           r_rx_state;
    state_t           w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [CNT_W-1:0] w_rx_cnt_nxt;
    logic [2:0]       r_rx_idx;
    logic [2:0]       w_rx_idx_nxt;
    logic [7:0]       r_rx_shift;
    logic [7:0]       w_rx_shift_nxt;
    logic [7:0]       r_rx_data;
    logic             r_rx_ready;
    logic             w_rx_bit_end;
    logic             w_rx_done;

`ifdef UART_LOOPBACK_EN
    assign w_rx_src = r_tx;
`else
    assign w_rx_src = rx;
`endif

    assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);

    // Synchronizer resets to the idle level so reset release is not a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= w_rx_src;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_ready <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_ready <= w_rx_done;
            if (w_rx_done) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    // Next-state logic. The half-bit wait in START moves every later sample
    // to mid-bit; STOP leaves at its mid-point so a back-to-back start edge
    // is seen from IDLE.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_idx_nxt   = r_rx_idx;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_rx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_idx_nxt   = '0;
                    w_rx_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_idx_nxt = r_rx_idx + 1'b1;
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_state_nxt = S_IDLE;
                    w_rx_cnt_nxt   = '0;
                end
            end
            default: begin
                w_rx_state_nxt = S_IDLE;
                w_rx_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: shift in LSB first; a low stop sample discards the byte.
    always_comb begin
        w_rx_shift_nxt = r_rx_shift;
        if ((r_rx_state == S_DATA) && w_rx_bit_end) begin
            w_rx_shift_nxt = {r_rx_s, r_rx_shift[7:1]};
        end
        w_rx_done = (r_rx_state == S_STOP) && w_rx_bit_end && r_rx_s;
    end

    assign rx_data  = r_rx_data;
    assign rx_ready = r_rx_ready;

endmodule

// File: tb/tb_uart_rx_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_tx
//   Scoreboard bench for uart_rx_tx at CLKS_PER_BIT = 10. Stimulus pushes the
//   expected tx frames and rx bytes into queues; two monitors pop and compare
//   whenever a frame appears on tx or rx_ready pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       rx       = 1'b1;
    logic       tx;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_ready;

    uart_rx_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_ready(rx_ready)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [9:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    int         last_rdy_cyc = -1;
    int         rdy_count    = 0;
    logic       rdy_prev     = 1'b0;
    logic       tx_act       = 1'b0;
    int         tx_cnt       = 0;
    logic [9:0] tx_bits      = '0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        exp_tx.push_back({1'b1, d, 1'b0});
`ifdef UART_LOOPBACK_EN
        exp_rx.push_back(d);
`endif
    endtask

    // Drives one full frame on rx starting at the current negedge.
    task automatic drive_rx(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RX monitor
    initial forever begin
        @(negedge clk);
        if (rx_ready === 1'b1) begin
            last_rdy_cyc = cyc;
            rdy_count++;
            if (rdy_prev === 1'b1) begin
                chk("rx_ready_width", 2, 1);
            end
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected actual=%0h expected=no_pulse", rx_data);
            end else begin
                chk("rx_data", rx_data, exp_rx.pop_front());
            end
        end
        rdy_prev = rx_ready;
    end

    // TX monitor: samples each bit mid-way; bit i of tx_bits is the i-th bit on the wire.
    initial forever begin
        @(negedge clk);
        if (reset !== 1'b1) begin
            tx_act = 1'b0;
        end else if (!tx_act && tx === 1'b0) begin
            tx_act = 1'b1;
            tx_cnt = 0;
        end
        if (tx_act) begin
            if ((tx_cnt % CPB) == CPB / 2) begin
                tx_bits[tx_cnt / CPB] = tx;
            end
            tx_cnt++;
            if (tx_cnt == 10 * CPB) begin
                tx_act = 1'b0;
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=%0h expected=no_frame", tx_bits);
                end else begin
                    chk("tx_frame", tx_bits, exp_tx.pop_front());
                end
            end
        end
    end

    int n;
    int t0;
    int rc;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_tx", tx, 1);
        chk("idle_tx_busy", tx_busy, 0);
        chk("idle_rx_data", rx_data, 8'h00);

        // Single frame 0x45; later tx_data change must not matter
        tx_data  = 8'h45;
        tx_start = 1'b1;
        push_tx(8'h45);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'hFF;
        chk("tx_busy_rise", tx_busy, 1);
        n = 0;
        while (tx_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("tx_busy_len", n, 10 * CPB);
        chk("tx_idle_after", tx, 1);
        repeat (20) @(negedge clk);

`ifndef UART_LOOPBACK_EN
        // Good rx frame 0x6E with latency check
        t0 = cyc;
        exp_rx.push_back(8'h6E);
        drive_rx(8'h6E, 1'b1);
        repeat (5) @(negedge clk);
        chk("rx_latency_ok", ((last_rdy_cyc - t0) >= 92 && (last_rdy_cyc - t0) <= 100) ? 1 : 0, 1);
        chk("rx_data_hold", rx_data, 8'h6E);

        // 3-clock glitch: false start, no output
        rc = rdy_count;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_no_ready", rdy_count, rc);

        // Framing error: byte discarded, rx_data unchanged
        drive_rx(8'hA5, 1'b0);
        repeat (30) @(negedge clk);
        chk("frame_err_no_ready", rdy_count, rc);
        chk("frame_err_rx_data", rx_data, 8'h6E);

        // Back-to-back rx frames
        exp_rx.push_back(8'h3C);
        exp_rx.push_back(8'hC3);
        drive_rx(8'h3C, 1'b1);
        drive_rx(8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        chk("rx_b2b_last", rx_data, 8'hC3);
        chk("rx_b2b_count", rdy_count, rc + 2);
`endif

        // tx_start held high: two frames, one idle cycle between
        tx_data  = 8'h41;
        tx_start = 1'b1;
        push_tx(8'h41);
        push_tx(8'h70);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy !== 1'b1 && n < 10);
        tx_data = 8'h70;
        n = 0;
        while (tx_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_first_len", n, 10 * CPB);
        n = 0;
        while (tx_busy !== 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_gap", n, 1);
        tx_start = 1'b0;
        n = 0;
        while (tx_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_second_done", tx_busy, 0);
        repeat (20) @(negedge clk);

        // Reset mid-frame aborts immediately
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_abort_busy", tx_busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_tx_busy", tx_busy, 0);
        chk("abort_rx_data", rx_data, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_abort_tx", tx, 1);

        // Frame 0x20 (looped back to rx_data when loopback is built in)
        tx_data  = 8'h20;
        tx_start = 1'b1;
        push_tx(8'h20);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (130) @(negedge clk);
`ifdef UART_LOOPBACK_EN
        chk("loopback_rx_data", rx_data, 8'h20);
`endif

        // Drain scoreboards
        n = 0;
        while ((exp_tx.size() != 0 || exp_rx.size() != 0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("exp_tx_left", exp_tx.size(), 0);
        chk("exp_rx_left", exp_rx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
